fx2_slave_fifo_model: RTL and testbench

Synthesizable responder for the CY68013 (FX2) slave-FIFO interface driven by the `usb` master block. It models EP2 (host-to-FPGA OUT FIFO) and EP6 (FPGA-to-host IN FIFO) with FX2 pin semantics on one side and valid/ready host-stream ports on the other. EP6 words become visible to the host only in committed packets. It serves as the far end of the USB link in loopback builds and in the `usb` block testbench.

---
 rtl/fx2_slave_fifo_model.sv | 121 ++++++++++++
 tb/tb_fx2_slave_fifo_model.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO far-end model: EP2 (host -> FX2 reads) and EP6 (FX2 writes -> host),
// with EP6 words released to the host only in committed packets.
module fx2_slave_fifo_model #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 9,
    parameter int PKT_WORDS  = 256
) (
    input  logic                  i_usb_ifclk,
    input  logic                  i_rst,
    inout  wire  [DATA_WIDTH-1:0] io_usb_data,
    input  logic [1:0]            i_usb_addr,
    input  logic                  i_usb_slrd,
    input  logic                  i_usb_slwr,
    input  logic                  i_usb_sloe,
    input  logic                  i_usb_pkend,
    output logic                  o_usb_flaga,
    output logic                  o_usb_flagd,
    input  logic [DATA_WIDTH-1:0] i_host_wr_data,
    input  logic                  i_host_wr_valid,
    output logic                  o_host_wr_ready,
    output logic [DATA_WIDTH-1:0] o_host_rd_data,
    output logic                  o_host_rd_valid,
    input  logic                  i_host_rd_ready,
    output logic [7:0]            o_zlp_count,
    output logic [2:0]            o_err
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam int              CW    = ADDR_W + 1;
    localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]   PKT   = CW'(PKT_WORDS);

    logic [DATA_WIDTH-1:0] ep2_mem [DEPTH];
    logic [DATA_WIDTH-1:0] ep6_mem [DEPTH];

    logic [ADDR_W-1:0] ep2_wr_ptr_q, ep2_wr_ptr_d, ep2_rd_ptr_q, ep2_rd_ptr_d;
    logic [ADDR_W-1:0] ep6_wr_ptr_q, ep6_wr_ptr_d, ep6_rd_ptr_q, ep6_rd_ptr_d;
    logic [CW-1:0]     ep2_cnt_q, ep2_cnt_d, ep6_total_q, ep6_total_d, ep6_cmt_q, ep6_cmt_d;
    logic [7:0]        zlp_q, zlp_d;
    logic [2:0]        err_q, err_d;
    logic              flaga_q, flagd_q, wr_ready_q, rd_valid_q;

    logic          rd_sel, wr_sel, conflict, fx2_rd, fx2_wr, host_push, host_pop, pkend;
    logic [CW-1:0] unc_after;
    logic          commit_all;

    always_comb begin
        rd_sel    = !i_usb_slrd && i_usb_slwr && (i_usb_addr == 2'b00);
        wr_sel    = !i_usb_slwr && i_usb_slrd && (i_usb_addr == 2'b10);
        conflict  = !i_usb_slrd && !i_usb_slwr;
        fx2_rd    = rd_sel && (ep2_cnt_q != '0);
        fx2_wr    = wr_sel && (ep6_total_q != FULL);
        host_push = i_host_wr_valid && wr_ready_q;
        host_pop  = rd_valid_q && i_host_rd_ready;
        pkend     = !i_usb_pkend && (i_usb_addr == 2'b10);

        ep2_wr_ptr_d = ep2_wr_ptr_q + ADDR_W'(host_push);
        ep2_rd_ptr_d = ep2_rd_ptr_q + ADDR_W'(fx2_rd);
        ep2_cnt_d    = ep2_cnt_q + CW'(host_push) - CW'(fx2_rd);

        ep6_wr_ptr_d = ep6_wr_ptr_q + ADDR_W'(fx2_wr);
        ep6_rd_ptr_d = ep6_rd_ptr_q + ADDR_W'(host_pop);
        ep6_total_d  = ep6_total_q + CW'(fx2_wr) - CW'(host_pop);

        // Uncommitted words including any write landing on this edge
        unc_after  = ep6_total_q - ep6_cmt_q + CW'(fx2_wr);
        commit_all = (fx2_wr && (unc_after == PKT)) || (pkend && (unc_after != '0));
        ep6_cmt_d  = commit_all ? ep6_total_d : (ep6_cmt_q - CW'(host_pop));

        zlp_d = zlp_q + 8'(pkend && (unc_after == '0));
        err_d = err_q | {conflict, wr_sel && !fx2_wr, rd_sel && !fx2_rd};
    end

    always_ff @(posedge i_usb_ifclk or posedge i_rst) begin
        if (i_rst) begin
            ep2_wr_ptr_q <= '0;
            ep2_rd_ptr_q <= '0;
            ep2_cnt_q    <= '0;
            ep6_wr_ptr_q <= '0;
            ep6_rd_ptr_q <= '0;
            ep6_total_q  <= '0;
            ep6_cmt_q    <= '0;
            zlp_q        <= '0;
            err_q        <= '0;
            flaga_q      <= 1'b0;
            flagd_q      <= 1'b1;
            wr_ready_q   <= 1'b1;
            rd_valid_q   <= 1'b0;
        end else begin
            ep2_wr_ptr_q <= ep2_wr_ptr_d;
            ep2_rd_ptr_q <= ep2_rd_ptr_d;
            ep2_cnt_q    <= ep2_cnt_d;
            ep6_wr_ptr_q <= ep6_wr_ptr_d;
            ep6_rd_ptr_q <= ep6_rd_ptr_d;
            ep6_total_q  <= ep6_total_d;
            ep6_cmt_q    <= ep6_cmt_d;
            zlp_q        <= zlp_d;
            err_q        <= err_d;
            flaga_q      <= (ep2_cnt_d != '0);
            flagd_q      <= (ep6_total_d != FULL);
            wr_ready_q   <= (ep2_cnt_d != FULL);
            rd_valid_q   <= (ep6_cmt_d != '0);
        end
    end

    // Storage arrays carry no reset; pointers alone define contents
    always_ff @(posedge i_usb_ifclk) begin
        if (host_push) ep2_mem[ep2_wr_ptr_q] <= i_host_wr_data;
        if (fx2_wr)    ep6_mem[ep6_wr_ptr_q] <= io_usb_data;
    end

    assign io_usb_data = (!i_rst && !i_usb_sloe && (i_usb_addr == 2'b00))
                         ? ep2_mem[ep2_rd_ptr_q] : {DATA_WIDTH{1'bz}};

    assign o_usb_flaga     = flaga_q;
    assign o_usb_flagd     = flagd_q;
    assign o_host_wr_ready = wr_ready_q;
    assign o_host_rd_valid = rd_valid_q;
    assign o_host_rd_data  = ep6_mem[ep6_rd_ptr_q];
    assign o_zlp_count     = zlp_q;
    assign o_err           = err_q;
endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model: EP2 vector table plus EP6 packet, full, conflict and reset sequences.
module tb_fx2_slave_fifo_model;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'b01;
    logic        slrd = 1'b1, slwr = 1'b1, sloe = 1'b1, pkend = 1'b1;
    logic [15:0] hwd = '0;
    logic        hwv = 1'b0, hrr = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dout = '0;
    wire  [15:0] usb_data;
    logic        flaga, flagd, wr_ready, rd_valid;
    logic [15:0] rd_data;
    logic [7:0]  zlp;
    logic [2:0]  err;
    int          tests = 0, fails = 0;

    assign usb_data = tb_oe ? tb_dout : 16'hzzzz;

    fx2_slave_fifo_model #(.DATA_WIDTH(16), .ADDR_W(9), .PKT_WORDS(256)) dut (
        .i_usb_ifclk(clk), .i_rst(rst), .io_usb_data(usb_data), .i_usb_addr(addr),
        .i_usb_slrd(slrd), .i_usb_slwr(slwr), .i_usb_sloe(sloe), .i_usb_pkend(pkend),
        .o_usb_flaga(flaga), .o_usb_flagd(flagd),
        .i_host_wr_data(hwd), .i_host_wr_valid(hwv), .o_host_wr_ready(wr_ready),
        .o_host_rd_data(rd_data), .o_host_rd_valid(rd_valid), .i_host_rd_ready(hrr),
        .o_zlp_count(zlp), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        slrd;
        logic        sloe;
        logic [1:0]  addr;
        logic        hv;
        logic [15:0] hd;
        logic        ex_flaga;
        logic        chk_bus;
        logic [15:0] ex_bus;
        logic [2:0]  ex_err;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slrd = 1'b1; slwr = 1'b1; sloe = 1'b1; pkend = 1'b1;
        addr = 2'b01; tb_oe = 1'b0; hwv = 1'b0; hrr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fx2_write(input logic [15:0] d, input logic with_pkend);
        addr = 2'b10; sloe = 1'b1; slrd = 1'b1; slwr = 1'b0;
        tb_oe = 1'b1; tb_dout = d; pkend = !with_pkend;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          slrd sloe addr   hv  hd      flaga chk bus     err
        tv[0]  = '{1'b1, 1'b1, 2'b01, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 3'b000};
        tv[1]  = '{1'b1, 1'b1, 2'b01, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000, 3'b000};
        tv[2]  = '{1'b1, 1'b1, 2'b01, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000, 3'b000};
        tv[3]  = '{1'b1, 1'b1, 2'b01, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000, 3'b000};
        tv[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 3'b000};
        tv[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 3'b000};
        tv[6]  = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 3'b000};
        tv[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 3'b000};
        tv[8]  = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'b000};
        tv[9]  = '{1'b1, 1'b0, 2'b00, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0005, 3'b000};
        tv[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 16'h0006, 1'b1, 1'b1, 16'h0006, 3'b000};
        tv[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'b000};

        do_reset();
        chk("rst_flaga", flaga, 1'b0);
        chk("rst_flagd", flagd, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_zlp", zlp, 8'd0);
        chk("rst_err", err, 3'b000);

        // EP2 ordering, FWFT and simultaneous push/read
        for (int i = 0; i < 12; i++) begin
            slrd = tv[i].slrd; sloe = tv[i].sloe; addr = tv[i].addr;
            hwv = tv[i].hv; hwd = tv[i].hd;
            tick();
            chk($sformatf("ep2_v%0d_flaga", i), flaga, tv[i].ex_flaga);
            if (tv[i].chk_bus) chk($sformatf("ep2_v%0d_bus", i), usb_data, tv[i].ex_bus);
            chk($sformatf("ep2_v%0d_err", i), err, tv[i].ex_err);
        end
        idle();

        // EP6 auto-commit at 256 words, then drain in order
        do_reset();
        for (int i = 0; i < 256; i++) begin
            fx2_write(16'h0100 + 16'(i), 1'b0);
            chk("auto_valid", rd_valid, (i == 255));
        end
        idle();
        hrr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            chk("auto_pop_valid", rd_valid, 1'b1);
            chk("auto_pop_data", rd_data, 16'h0100 + 16'(i));
            tick();
        end
        hrr = 1'b0;
        chk("auto_drained", rd_valid, 1'b0);

        // PKEND commit including same-edge write, ZLP, ignored PKEND on other address
        do_reset();
        for (int i = 0; i < 3; i++) fx2_write(16'h00A0 + 16'(i), 1'b0);
        chk("pk_uncommitted", rd_valid, 1'b0);
        fx2_write(16'h00A3, 1'b1);
        idle();
        chk("pk_committed", rd_valid, 1'b1);
        hrr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pk_pop_data", rd_data, 16'h00A0 + 16'(i));
            tick();
        end
        hrr = 1'b0;
        chk("pk_drained", rd_valid, 1'b0);
        addr = 2'b10; pkend = 1'b0;
        tick();
        idle();
        chk("zlp_count", zlp, 8'd1);
        tick();
        chk("zlp_no_data", rd_valid, 1'b0);
        fx2_write(16'h00B0, 1'b0);
        idle();
        addr = 2'b00; pkend = 1'b0;
        tick();
        idle();
        chk("pk_wrong_addr_valid", rd_valid, 1'b0);
        chk("pk_wrong_addr_zlp", zlp, 8'd1);
        addr = 2'b10; pkend = 1'b0;
        tick();
        idle();
        chk("pk_late_valid", rd_valid, 1'b1);
        chk("pk_late_data", rd_data, 16'h00B0);
        chk("pk_late_zlp", zlp, 8'd1);

        // EP6 full, dropped write, empty EP2 read
        do_reset();
        for (int i = 0; i < 512; i++) begin
            fx2_write(16'(i), 1'b0);
            chk("full_flagd", flagd, (i != 511));
        end
        fx2_write(16'hDEAD, 1'b0);
        idle();
        chk("full_drop_err", err, 3'b010);
        chk("full_flagd_hold", flagd, 1'b0);
        chk("full_head_intact", rd_data, 16'h0000);
        chk("full_head_valid", rd_valid, 1'b1);
        addr = 2'b00; slrd = 1'b0;
        tick();
        idle();
        chk("empty_rd_err", err, 3'b011);
        chk("empty_rd_flaga", flaga, 1'b0);

        // Strobe conflict: nothing moves
        do_reset();
        hwv = 1'b1; hwd = 16'h0077;
        tick();
        hwv = 1'b0;
        addr = 2'b00; slrd = 1'b0; slwr = 1'b0;
        tick();
        idle();
        chk("conf_flaga", flaga, 1'b1);
        chk("conf_err", err, 3'b100);
        addr = 2'b10; tb_oe = 1'b1; tb_dout = 16'h5555; slrd = 1'b0; slwr = 1'b0;
        tick();
        idle();
        addr = 2'b10; pkend = 1'b0;
        tick();
        idle();
        chk("conf_no_ep6_word", zlp, 8'd1);
        chk("conf_no_ep6_valid", rd_valid, 1'b0);
        sloe = 1'b0; addr = 2'b00;
        #1;
        chk("conf_ep2_head", usb_data, 16'h0077);
        idle();

        // Reset mid-packet discards partial packet
        for (int i = 0; i < 3; i++) fx2_write(16'h0C00 + 16'(i), 1'b0);
        idle();
        hwv = 1'b1; hwd = 16'h0088;
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flaga", flaga, 1'b0);
        chk("mid_rst_flagd", flagd, 1'b1);
        chk("mid_rst_wr_ready", wr_ready, 1'b1);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_zlp", zlp, 8'd0);
        chk("mid_rst_err", err, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        addr = 2'b10; pkend = 1'b0;
        tick();
        idle();
        chk("post_rst_zlp", zlp, 8'd1);
        chk("post_rst_rd_valid", rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
